// File: rtl/cnn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnn_pkg : shared types and helpers for the convolution pipeline
// Rev 1.0
// ----------------------------------------------------------------------------
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;

  // Frame-memory address width; never narrower than one bit.
  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_skid : 2-entry ready/valid skid buffer carrying data, sol and eof
// Rev 1.0
// ----------------------------------------------------------------------------
module stream_skid #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_sol,
  input  logic          i_eof,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_sol,
  output logic          o_eof,
  output logic [1:0]    o_count
);

  logic [DW-1:0] data_q [2];
  logic [DW-1:0] data_d [2];
  logic [1:0]    sol_q, sol_d;
  logic [1:0]    eof_q, eof_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          push, pop;

  assign o_valid = (count_q != 2'd0);
  assign o_data  = data_q[rd_ptr_q];
  assign o_sol   = o_valid & sol_q[rd_ptr_q];
  assign o_eof   = o_valid & eof_q[rd_ptr_q];
  assign o_count = count_q;

  // A write into a full buffer is only legal when the head leaves the same cycle.
  assign pop  = o_valid && i_ready;
  assign push = i_valid && ((count_q != 2'd2) || pop);

  always_comb begin
    data_d   = data_q;
    sol_d    = sol_q;
    eof_d    = eof_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      data_d[wr_ptr_q] = i_data;
      sol_d[wr_ptr_q]  = i_sol;
      eof_d[wr_ptr_q]  = i_eof;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q   <= '{default: '0};
      sol_q    <= '0;
      eof_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      sol_q    <= sol_d;
      eof_q    <= eof_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/image_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// image_streamer : raster-order frame reader with optional zero border
// Rev 1.0
// ----------------------------------------------------------------------------
module image_streamer
  import cnn_pkg::*;
#(
  parameter  int dataWidth   = 8,
  parameter  int imageWidth  = 512,
  parameter  int imageHeight = 512,
  parameter  int PAD         = 0,
  localparam int AW          = addr_width(imageWidth, imageHeight)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [AW-1:0]        o_mem_addr,
  output logic                 o_mem_rd_en,
  input  logic [dataWidth-1:0] i_mem_data,
  output logic [dataWidth-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_ready,
  output logic                 o_sol,
  output logic                 o_eof
);

  localparam int OW = imageWidth + 2 * PAD;
  localparam int OH = imageHeight + 2 * PAD;
  localparam int CW = $clog2(OW);
  localparam int RW = $clog2(OH);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_zero_q, s1_zero_d;
  logic                 s1_sol_q, s1_sol_d;
  logic                 s1_eof_q, s1_eof_d;
  logic                 done_q, done_d;

  logic                 border;
  logic                 last_pos;
  logic                 issue;
  logic                 skid_pop;
  logic [1:0]           skid_count;
  logic [2:0]           occupancy;
  logic [2:0]           occupancy_limit;
  logic [dataWidth-1:0] ret_data;

  generate
    if (PAD == 1) begin : g_pad
      assign border = (row_q == '0) || (row_q == ROW_LAST) ||
                      (col_q == '0) || (col_q == COL_LAST);
    end else begin : g_nopad
      assign border = 1'b0;
    end
  endgenerate

  assign last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign skid_pop = o_data_valid && i_ready;

  // Everything issued now or already in flight must still fit in the skid
  // even if downstream stalls from the next cycle on.
  assign occupancy       = {1'b0, skid_count} + {2'b00, s1_valid_q};
  assign occupancy_limit = 3'd1 + {2'b00, skid_pop};
  assign issue           = (state_q == STREAM) && (occupancy <= occupancy_limit);

  assign o_mem_rd_en = issue && !border;
  assign o_mem_addr  = addr_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    s1_valid_d = issue;
    s1_zero_d  = border;
    s1_sol_d   = (col_q == '0);
    s1_eof_d   = last_pos;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = STREAM;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      STREAM: begin
        if (issue) begin
          // Interior pixels are visited in row-major order, so the read
          // address is simply a running count of interior issues.
          if (!border) begin
            addr_d = addr_q + AW'(1);
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (last_pos) begin
              state_d = DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (skid_pop && o_eof) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_sol_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      s1_valid_q <= s1_valid_d;
      s1_zero_q  <= s1_zero_d;
      s1_sol_q   <= s1_sol_d;
      s1_eof_q   <= s1_eof_d;
      done_q     <= done_d;
    end
  end

  assign ret_data = s1_zero_q ? '0 : i_mem_data;

  stream_skid #(
    .DW (dataWidth)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (s1_valid_q),
    .i_data  (ret_data),
    .i_sol   (s1_sol_q),
    .i_eof   (s1_eof_q),
    .o_valid (o_data_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sol   (o_sol),
    .o_eof   (o_eof),
    .o_count (skid_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_image_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_image_streamer : scoreboard bench for image_streamer (4x3, PAD 0 and 1)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_image_streamer;

  localparam int W = 4;
  localparam int H = 3;

  typedef struct packed {
    logic [7:0] d;
    logic       sol;
    logic       eof;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0, start1, ready0, ready1;
  logic       busy0, busy1, done0, done1;
  logic [3:0] addr0, addr1;
  logic       rd0, rd1;
  logic [7:0] mdata0 = 8'd0;
  logic [7:0] mdata1 = 8'd0;
  logic [7:0] data0, data1;
  logic       valid0, valid1, sol0, sol1, eof0, eof1;

  int    checks   = 0;
  int    failures = 0;
  beat_t q0[$];
  beat_t q1[$];
  int    acc0 = 0, acc1 = 0, rd_cnt0 = 0, rd_cnt1 = 0, max_occ0 = 0;
  beat_t held0;
  logic  have_held0 = 1'b0;
  int    cur = 0;
  int    at;

  always #5 clk = ~clk;

  image_streamer #(.dataWidth(8), .imageWidth(W), .imageHeight(H), .PAD(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_busy(busy0), .o_done(done0),
    .o_mem_addr(addr0), .o_mem_rd_en(rd0), .i_mem_data(mdata0), .o_data(data0),
    .o_data_valid(valid0), .i_ready(ready0), .o_sol(sol0), .o_eof(eof0)
  );

  image_streamer #(.dataWidth(8), .imageWidth(W), .imageHeight(H), .PAD(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_mem_addr(addr1), .o_mem_rd_en(rd1), .i_mem_data(mdata1), .o_data(data1),
    .o_data_valid(valid1), .i_ready(ready1), .o_sol(sol1), .o_eof(eof1)
  );

  // Frame memory: word at address a holds a+1, one cycle read latency.
  always @(posedge clk) begin
    if (rd0) mdata0 <= 8'({4'd0, addr0}) + 8'd1;
    if (rd1) mdata1 <= 8'({4'd0, addr1}) + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      have_held0 = 1'b0;
    end else begin
      if (have_held0 && valid0) check("hold0", 32'({data0, sol0, eof0}), 32'(held0));
      have_held0 = valid0 && !ready0;
      held0      = {data0, sol0, eof0};
      if (rd_cnt0 - acc0 > max_occ0) max_occ0 = rd_cnt0 - acc0;
      if (rd0) rd_cnt0++;
      if (rd1) rd_cnt1++;
      if (valid0 && ready0) begin
        check("sb0_nonempty", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("beat0", 32'({data0, sol0, eof0}), 32'(e));
        end
        acc0++;
      end
      if (valid1 && ready1) begin
        check("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("beat1", 32'({data1, sol1, eof1}), 32'(e));
        end
        acc1++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic push_frame0();
    beat_t b;
    for (int i = 0; i < W * H; i++) begin
      b.d   = 8'(i + 1);
      b.sol = (i % W) == 0;
      b.eof = (i == W * H - 1);
      q0.push_back(b);
    end
  endtask

  task automatic push_frame1();
    beat_t b;
    for (int r = 0; r < H + 2; r++) begin
      for (int c = 0; c < W + 2; c++) begin
        if (r == 0 || r == H + 1 || c == 0 || c == W + 1) b.d = 8'd0;
        else b.d = 8'((r - 1) * W + (c - 1) + 1);
        b.sol = (c == 0);
        b.eof = (r == H + 1) && (c == W + 1);
        q1.push_back(b);
      end
    end
  endtask

  task automatic wait_done(input int which, input int budget, output int done_at);
    done_at = -1;
    for (int k = 0; k < budget; k++) begin
      if ((which == 0) ? done0 : done1) begin
        done_at = cur;
        break;
      end
      tick();
    end
  endtask

  task automatic start_dut0();
    cur    = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_busy0",  32'(busy0),  32'd0);
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_rd0",    32'(rd0),    32'd0);
    check("rst_done0",  32'(done0),  32'd0);
    check("rst_addr0",  32'(addr0),  32'd0);
    check("rst_out0",   32'({data0, sol0, eof0}), 32'd0);
    check("rst_busy1",  32'({busy1, valid1}), 32'd0);

    // Plain frame, ready held high
    acc0 = 0; rd_cnt0 = 0;
    push_frame0();
    start_dut0();
    check("t1_c1", 32'({busy0, rd0, addr0}), 32'b110000);
    tick();
    check("t1_c2_valid", 32'(valid0), 32'd0);
    tick();
    check("t1_c3", 32'({valid0, data0, sol0}), 32'({1'b1, 8'd1, 1'b1}));
    wait_done(0, 50, at);
    check("t1_done_cycle", 32'(at), 32'd15);
    check("t1_reads", 32'(rd_cnt0), 32'd12);
    check("t1_sb_empty", 32'(q0.size()), 32'd0);

    // Zero border
    rd_cnt1 = 0;
    push_frame1();
    cur = 0; start1 = 1'b1; tick(); start1 = 1'b0;
    check("t2_c1", 32'({busy1, rd1}), 32'b10);
    wait_done(1, 100, at);
    check("t2_done_cycle", 32'(at), 32'd33);
    check("t2_reads", 32'(rd_cnt1), 32'd12);
    check("t2_sb_empty", 32'(q1.size()), 32'd0);

    // Downstream ready toggling 1,0,0,1
    acc0 = 0; rd_cnt0 = 0; max_occ0 = 0;
    push_frame0();
    start_dut0();
    at = -1;
    for (int k = 0; k < 200; k++) begin
      ready0 = (cur % 4 == 0) || (cur % 4 == 3);
      if (done0) begin
        at = cur;
        break;
      end
      tick();
    end
    ready0 = 1'b1;
    check("t3_done_seen", 32'(at > 0), 32'd1);
    check("t3_beats", 32'(acc0), 32'd12);
    check("t3_occupancy", 32'(max_occ0 <= 2), 32'd1);
    check("t3_sb_empty", 32'(q0.size()), 32'd0);

    // Reset after the sixth beat
    acc0 = 0; rd_cnt0 = 0;
    push_frame0();
    start_dut0();
    for (int k = 0; k < 50 && acc0 < 6; k++) tick();
    check("t4_reach6", 32'(acc0), 32'd6);
    rst = 1'b1;
    q0.delete();
    tick();
    rst = 1'b0;
    check("t4_after_rst", 32'({valid0, busy0}), 32'd0);
    acc0 = 0; rd_cnt0 = 0;
    push_frame0();
    start_dut0();
    tick(); tick();
    check("t4_c3", 32'({valid0, data0, sol0}), 32'({1'b1, 8'd1, 1'b1}));
    wait_done(0, 50, at);
    check("t4_done_cycle", 32'(at), 32'd15);

    // Start held high: two back-to-back frames
    push_frame0();
    push_frame0();
    cur = 0; start0 = 1'b1; tick();
    wait_done(0, 50, at);
    check("t5_done1_cycle", 32'(at), 32'd15);
    tick();
    check("t5_c16_valid", 32'({busy0, valid0}), 32'b10);
    tick();
    check("t5_c17_valid", 32'(valid0), 32'd0);
    tick();
    check("t5_c18", 32'({valid0, data0, sol0}), 32'({1'b1, 8'd1, 1'b1}));
    tick(); tick();
    start0 = 1'b0;
    wait_done(0, 50, at);
    check("t5_done2_cycle", 32'(at), 32'd30);
    tick(); tick(); tick();
    check("t5_no_third", 32'({busy0, valid0}), 32'd0);
    check("t5_sb_empty", 32'(q0.size()), 32'd0);

    // Ready low for 20 cycles from the start
    ready0 = 1'b0;
    push_frame0();
    start_dut0();
    while (cur < 20) tick();
    check("t6_held", 32'({busy0, valid0, data0, sol0}), 32'({1'b1, 1'b1, 8'd1, 1'b1}));
    ready0 = 1'b1;
    wait_done(0, 50, at);
    check("t6_done_cycle", 32'(at), 32'd32);
    check("t6_sb_empty", 32'(q0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
